ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch stage of the MINAv2 core.
//  - Owns the PC and drives imem.addr from it.
//  - Captures imem.data (combinational read) together with its PC into a small
//    fetch queue, and presents entries to decode over a valid/ready handshake.
//  - Accepts redirects (branch/jump/trap) from downstream. A redirect flushes
//    all queued instructions.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; must be word-aligned
//  FQ_DEPTH  2              fetch queue entries; power of two, >= 2
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst_n           in   1   reset: synchronous, active-low
//  imem_addr       out  32  byte address to imem; always equals pc register
//  imem_data       in   32  instruction word returned by imem, same cycle
//  redirect_valid  in   1   load new PC and flush the queue this cycle
//  redirect_pc     in   32  target PC; bits [1:0] ignored (forced to 0)
//  dec_valid       out  1   queue head holds a valid instruction
//  dec_ready       in   1   decode accepts the head entry this cycle
//  dec_instr       out  32  head instruction; 32'h0 when dec_valid=0
//  dec_pc          out  32  PC of the head instruction; 32'h0 when dec_valid=0
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge):
//  - pc <= RESET_PC; queue count/head/tail <= 0; dec_valid=0.
//  - dec_instr=0, dec_pc=0; imem_addr=RESET_PC in the following cycle.
//  Combinational signals:
//  - pop  = dec_valid & dec_ready.
//  - push = !redirect_valid & (count < FQ_DEPTH | pop).
//  Normal cycle (no redirect):
//  - On push: write {pc, imem_data} at tail; tail++; pc <= pc + 32'd4.
//  - On pop: head++.
//  - count <= count + push - pop.
//  - Push while full is legal only with a simultaneous pop (pass-through at full).
//  - With no push, pc holds and imem_addr is stable (fetch stall).
//  Redirect (redirect_valid=1; takes priority over everything):
//  - count, head, tail <= 0; pc <= {redirect_pc[31:2], 2'b00}.
//  - No push this cycle. A same-cycle pop still counts as accepted by decode;
//    the entry is not replayed.
//  - The first fetched target is presented (dec_valid=1) one cycle after the
//    redirect edge.
//  Latency: an instruction fetched at edge N is visible on dec_* after edge N.
//  Throughput: 1 instruction/cycle when dec_ready is held at 1.
//  Arithmetic/width rules:
//  - pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
//  - Address aliasing above the imem size is imem's concern, not ifetch's.
//  - Head/tail pointers are $clog2(FQ_DEPTH) bits and wrap naturally.
//  - count is $clog2(FQ_DEPTH)+1 bits.
//  Boundary conditions:
//  - Empty queue: dec_valid=0; dec_ready is ignored.
//  - Full queue with dec_ready=0: pc frozen, no overwrite of any entry.
//  - Reset mid-stream: the queue is discarded; no partial entry survives.
//  - dec_* are combinational from the head entry only; imem_data never bypasses
//    the queue to dec_*.
// STRUCTURE
//  - Add to the types package: fetch_entry_t struct packed {u32_t pc; u32_t instr;}
//    and localparam u32_t MINA_RESET_PC = '0.
//  - Sub-module fetch_queue holds the FQ_DEPTH x fetch_entry_t circular buffer.
//    Interface: push, pop, flush, count, head entry, with the same sync active-low
//    rst_n.
//  - ifetch keeps only the PC register and the push/pop/redirect control.
// TESTING
//  1. Reset with RESET_PC=0 -> imem_addr=0, dec_valid=0, dec_instr=0, dec_pc=0;
//     one cycle after reset release: dec_valid=1, dec_pc=0.
//  2. dec_ready=1, imem preloaded 0x11,0x22,0x33 -> dec_pc 0,4,8 on consecutive
//     cycles; dec_instr matches; no bubbles.
//  3. dec_ready=0 for 5 cycles -> queue holds pc 0,4; imem_addr frozen at 8;
//     on release, dec_pc 0,4,8 delivered in order with no loss or duplication.
//  4. Full queue, redirect_valid=1, redirect_pc=32'h103 -> next cycle
//     dec_valid=1, dec_pc=32'h100; old entries are never presented.
//  5. Redirect in the same cycle as pop (dec_ready=1) -> the popped entry counts
//     as accepted once; the next dec_pc is the target.
//  6. Force pc=32'hFFFF_FFFC via redirect -> following imem_addr=0; assert rst_n=0
//     with a full queue -> next cycle dec_valid=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types for the MINAv2 fetch stage.
package ifetch_pkg;

  typedef logic [31:0] u32_t;

  typedef struct packed {
    u32_t pc;
    u32_t instr;
  } fetch_entry_t;

  localparam u32_t MINA_RESET_PC = '0;

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: imem read port, redirect input and decode handshake.
interface ifetch_if;
  import ifetch_pkg::*;

  u32_t imem_addr;
  u32_t imem_data;
  logic redirect_valid;
  u32_t redirect_pc;
  logic dec_valid;
  logic dec_ready;
  u32_t dec_instr;
  u32_t dec_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc
  );
endinterface

// File: rtl/ifetch_fetch_queue.sv
// Circular buffer of fetched {pc, instr} entries; flush discards everything.
module ifetch_fetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  fetch_entry_t    wdata_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  fetch_entry_t    mem_q [Depth];
  fetch_entry_t    mem_d [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q] = wdata_i;
        tail_d        = tail_q + 1'b1;
      end
      if (pop_i) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  // Entry storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/ifetch.sv
// MINAv2 instruction fetch: PC register plus push/pop/redirect control.
module ifetch
  import ifetch_pkg::*;
#(
  parameter u32_t        RESET_PC = MINA_RESET_PC,
  parameter int unsigned FQ_DEPTH = 2
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FQ_DEPTH);

  u32_t            pc_q, pc_d;
  logic            push, pop, dec_valid;
  logic [CntW-1:0] count;
  fetch_entry_t    head, wdata;

  ifetch_fetch_queue #(
    .Depth (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (wdata),
    .count_o (count),
    .head_o  (head)
  );

  always_comb begin
    dec_valid = (count != '0);
    pop       = dec_valid & bus.dec_ready;
    // Pass-through at full: a pop frees the slot the push fills.
    push      = !bus.redirect_valid & ((count < FullCnt) | pop);
    wdata     = '{pc: pc_q, instr: bus.imem_data};
    pc_d      = pc_q;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = dec_valid;
  assign bus.dec_instr = dec_valid ? head.instr : 32'h0;
  assign bus.dec_pc    = dec_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus randomized traffic vs a queue model.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem [256];
  int          tests;
  int          fails;

  ent_t        mq [$];
  logic [31:0] mpc;

  ifetch_if bus ();

  assign bus.imem_data = imem[bus.imem_addr[9:2]];

  ifetch #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dec_valid, dec_pc, dec_instr, imem_addr} predicted by the model.
  function automatic logic [96:0] model_out();
    if (mq.size() != 0) return {1'b1, mq[0].pc, mq[0].instr, mpc};
    return {1'b0, 32'h0, 32'h0, mpc};
  endfunction

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic pop;
    rst_n              = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.dec_ready      = rdy;
    @(posedge clk);
    if (!r) begin
      mq.delete();
      mpc = RESET_PC;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (rv) begin
        mq.delete();
        mpc = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < DEPTH) begin
          mq.push_back({mpc, imem[mpc[9:2]]});
          mpc = mpc + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.imem_addr} !== {1'b0, 96'h0}) begin
      fails++;
      $display("FAIL reset_state: got v=%0b pc=%h instr=%h addr=%h, want all zero",
               bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.imem_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 32'h0, 32'h11}) begin
      fails++;
      $display("FAIL reset_release: got v=%0b pc=%h instr=%h, want 1/0/00000011",
               bus.dec_valid, bus.dec_pc, bus.dec_instr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 32'(4 * i), exp_instr[i]}) begin
        fails++;
        $display("FAIL stream[%0d]: got v=%0b pc=%h instr=%h, want 1/%h/%h", i,
                 bus.dec_valid, bus.dec_pc, bus.dec_instr, 32'(4 * i), exp_instr[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({bus.imem_addr, bus.dec_pc} !== {32'h8, 32'h0}) begin
      fails++;
      $display("FAIL stall_frozen: got addr=%h pc=%h, want 00000008/00000000",
               bus.imem_addr, bus.dec_pc);
    end
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({bus.dec_valid, bus.dec_pc} !== {1'b1, 32'(4 * i)}) begin
        fails++;
        $display("FAIL stall_release[%0d]: got v=%0b pc=%h, want 1/%h", i,
                 bus.dec_valid, bus.dec_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h103, 1'b0);
    tests++;
    if ({bus.dec_valid, bus.imem_addr} !== {1'b0, 32'h100}) begin
      fails++;
      $display("FAIL redirect_flush: got v=%0b addr=%h, want 0/00000100",
               bus.dec_valid, bus.imem_addr);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({bus.dec_valid, bus.dec_pc, bus.dec_instr} !== {1'b1, 32'h100, imem[64]}) begin
      fails++;
      $display("FAIL redirect_target: got v=%0b pc=%h instr=%h, want 1/00000100/%h",
               bus.dec_valid, bus.dec_pc, bus.dec_instr, imem[64]);
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      tests++;
      if ({bus.dec_valid, bus.dec_pc} !== {1'b1, 32'h40 + 32'(4 * i)}) begin
        fails++;
        $display("FAIL redirect_pop[%0d]: got v=%0b pc=%h, want 1/%h", i,
                 bus.dec_valid, bus.dec_pc, 32'h40 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({bus.imem_addr, bus.dec_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
      fails++;
      $display("FAIL pc_wrap: got addr=%h pc=%h, want 00000000/fffffffc",
               bus.imem_addr, bus.dec_pc);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    tests++;
    if ({bus.dec_valid, bus.dec_pc, bus.imem_addr} !== {1'b0, 32'h0, RESET_PC}) begin
      fails++;
      $display("FAIL reset_full: got v=%0b pc=%h addr=%h, want 0/0/%h",
               bus.dec_valid, bus.dec_pc, bus.imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [96:0] exp;
    logic        r, rv, rdy;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 63) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = $urandom;
      step(r, rv, rpc, rdy);
      exp = model_out();
      tests++;
      if ({bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.imem_addr} !== exp) begin
        fails++;
        $display("FAIL random[%0d]: got v=%0b pc=%h instr=%h addr=%h, want v=%0b pc=%h instr=%h addr=%h",
                 i, bus.dec_valid, bus.dec_pc, bus.dec_instr, bus.imem_addr,
                 exp[96], exp[95:64], exp[63:32], exp[31:0]);
      end
    end
  endtask

  initial begin
    tests              = 0;
    fails              = 0;
    mpc                = RESET_PC;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0] = 32'h11;
    imem[1] = 32'h22;
    imem[2] = 32'h33;

    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap_and_reset();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
